mem_stage_ctrl: RTL

Memory-stage controller of the pipelined processor. It consumes the EX/MEM pipeline register outputs and performs the data-memory access over a variable-latency request/acknowledge bus. It stalls the upstream pipeline while an access is outstanding and latches the MEM/WB pipeline register. Misaligned accesses and bus timeouts complete with an error flag instead of hanging the pipeline.

---
 rtl/mem_stage_ctrl_if.sv | 35 +++
 rtl/mem_stage_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Data-memory request/acknowledge bus between the memory-stage controller
// (master) and the data memory (slave).
//   mem_req   : access request, held until acknowledge or timeout
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word address, bits [1:0] always zero
//   mem_wdata : store data
//   mem_rdata : load data, valid in the cycle mem_ack is high
//   mem_ack   : access complete
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory stage of the pipeline: performs the data-memory access for the
// instruction held in EX/MEM, stalls upstream stages while the access is
// outstanding and loads the MEM/WB pipeline register every cycle.
// Misaligned accesses and bus timeouts complete with errW=1.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   validM..pcEM        : EX/MEM pipeline register outputs
//   stallM              : stall request to EX/MEM and earlier stages
//   bus                 : data-memory request/acknowledge bus (master side)
//   validW..writeregW   : MEM/WB pipeline register
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    validM,
    input  logic                    memreadM,
    input  logic                    memwriteM,
    input  logic                    regwriteM,
    input  logic                    memtoregM,
    input  logic [31:0]             aluoutM,
    input  logic [31:0]             WriteDataM,
    input  logic [4:0]              writeregM,
    input  logic [31:0]             pcEM,
    output logic                    stallM,
    mem_stage_ctrl_if.master        bus,
    output logic                    validW,
    output logic                    regwriteW,
    output logic                    memtoregW,
    output logic                    errW,
    output logic [31:0]             readdataW,
    output logic [31:0]             aluoutW,
    output logic [31:0]             pcMW,
    output logic [4:0]              writeregW
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 32'd1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        w_memop;
    logic        w_aligned;
    logic        w_req;
    logic        w_stall;
    logic        w_complete;
    logic        w_err;

    logic        w_valid_nxt;
    logic        w_regwrite_nxt;
    logic        w_err_nxt;
    logic [31:0] w_readdata_nxt;

    assign w_memop   = validM & (memreadM | memwriteM);
    assign w_aligned = (aluoutM[1:0] == 2'b00);

    // Request and stall are gated by reset so an abandoned access drops the bus at once.
    assign bus.mem_req   = w_req & ~reset;
    assign bus.mem_we    = memwriteM;
    assign bus.mem_addr  = {aluoutM[31:2], 2'b00};
    assign bus.mem_wdata = WriteDataM;
    assign stallM        = w_stall & ~reset;

    // State register and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and access-control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && w_aligned) begin
                    w_req = 1'b1;
                    if (bus.mem_ack) begin
                        w_complete = 1'b1;
                    end else begin
                        // First request cycle counts as cycle 1 toward the timeout.
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 8'd1;
                    end
                end else if (w_memop) begin
                    w_err = 1'b1;
                end else begin
                    w_err = 1'b0;
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (bus.mem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == TIMEOUT_M1) begin
                    w_complete  = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // MEM/WB next values: bubble while stalled, error forces regwrite off.
    always_comb begin
        w_valid_nxt    = validM;
        w_regwrite_nxt = regwriteM & ~w_err;
        w_err_nxt      = w_err;
        w_readdata_nxt = 32'd0;
        if (w_stall) begin
            w_valid_nxt    = 1'b0;
            w_regwrite_nxt = 1'b0;
            w_err_nxt      = 1'b0;
        end else if (w_complete && memreadM && !w_err) begin
            w_readdata_nxt = bus.mem_rdata;
        end else begin
            w_readdata_nxt = 32'd0;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validW    <= 1'b0;
            regwriteW <= 1'b0;
            memtoregW <= 1'b0;
            errW      <= 1'b0;
            readdataW <= 32'd0;
            aluoutW   <= 32'd0;
            pcMW      <= 32'd0;
            writeregW <= 5'd0;
        end else begin
            validW    <= w_valid_nxt;
            regwriteW <= w_regwrite_nxt;
            memtoregW <= memtoregM;
            errW      <= w_err_nxt;
            readdataW <= w_readdata_nxt;
            aluoutW   <= aluoutM;
            pcMW      <= pcEM;
            writeregW <= writeregM;
        end
    end

endmodule
